// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions for the Tomasulo datapath.
// Provides the default bus widths, the reserved "no producer" tag and
// the beat type that both the arbiter and the reservation stations
// use to describe one broadcast on the CDB.
package cdb_pkg;

    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 4;

    // Tag 0 never names a producer; a station operand holding it is ready.
    localparam logic [CDB_TAG_W-1:0] CDB_TAG_NONE = '0;

    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_beat_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bus between the CDB arbiter and its reservation stations.
//   req / req_data / cdb_enable : station-side requests and bus availability
//   accepted                    : one-hot grant back to the stations
//   cdb_valid / cdb_tag / cdb_data : registered broadcast beat snooped by all
//   bcast_count                 : broadcasts since reset (wraps at 255)
// Modport master is the arbiter, slave is the station side.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = cdb_pkg::CDB_DATA_W,
    parameter int TAG_W   = cdb_pkg::CDB_TAG_W
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      cdb_enable;
    logic [NUM_REQ-1:0]        accepted;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [7:0]                bcast_count;

    modport master (
        input  req, req_data, cdb_enable,
        output accepted, cdb_valid, cdb_tag, cdb_data, bcast_count
    );

    modport slave (
        output req, req_data, cdb_enable,
        input  accepted, cdb_valid, cdb_tag, cdb_data, bcast_count
    );

endinterface

// File: rtl/cdb_arbiter_rr_priority_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   grant : one-hot of the first set request at or above ptr (wrapping)
//   idx   : binary index of that request
//   any   : at least one request is set
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        // NOTE: every output gets a default before the search so no path
        // leaves one unassigned, which would otherwise infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus master: grants one completing reservation station per
// cycle in round-robin order and broadcasts its result one cycle later.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : master side of cdb_arbiter_if (requests in, accept and
//                registered valid/tag/data beat plus broadcast count out)
// Station i broadcasts tag TAG_BASE+i; TAG_BASE+NUM_REQ-1 must fit in TAG_W.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = CDB_DATA_W,
    parameter int TAG_W    = CDB_TAG_W,
    parameter int TAG_BASE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    cdb_arbiter_if.master bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] pick_grant;
    logic [PTR_W-1:0]   win_idx;
    logic               pick_any;
    logic               fire;

    rr_priority_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (win_idx),
        .any   (pick_any)
    );

    // rst_n gates the accept directly so no station sees a grant while
    // it is itself being reset.
    assign fire = rst_n && bus.cdb_enable && pick_any;

    always_comb begin
        bus.accepted = '0;
        if (fire) bus.accepted = pick_grant;
    end

    // NOTE: state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            bus.cdb_valid   <= 1'b0;
            bus.cdb_tag     <= TAG_W'(CDB_TAG_NONE);
            bus.cdb_data    <= '0;
            bus.bcast_count <= '0;
        end else if (fire) begin
            bus.cdb_valid   <= 1'b1;
            bus.cdb_tag     <= TAG_W'(TAG_BASE) + TAG_W'(win_idx);
            bus.cdb_data    <= bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
            rr_ptr          <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            bus.bcast_count <= bus.bcast_count + 8'd1;
        end else begin
            // Tag and data keep the last beat; only valid drops.
            bus.cdb_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 4;
    localparam int TAG_W    = 4;
    localparam int TAG_BASE = 1;

    logic clk;
    logic rst_n;

    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    cdb_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .TAG_W    (TAG_W),
        .TAG_BASE (TAG_BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    cdb_beat_t  exp_q[$];
    logic       exp_valid;
    logic [7:0] exp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the beat a grant must produce on the following cycle.
    task automatic push_expected(input logic [3:0] acc, input logic [15:0] d);
        cdb_beat_t b;
        int        w;
        w = 0;
        for (int i = 0; i < NUM_REQ; i++) if (acc[i]) w = i;
        b.valid = 1'b1;
        b.tag   = 4'(TAG_BASE + w);
        b.data  = d[w*DATA_W +: DATA_W];
        exp_q.push_back(b);
    endtask

    // Called just after a rising edge: drive one cycle, check at the falling edge.
    task automatic step(input logic [3:0] r, input logic [15:0] d, input logic en,
                        input logic [3:0] exp_acc);
        bus.req        = r;
        bus.req_data   = d;
        bus.cdb_enable = en;
        @(negedge clk);
        check("accepted", 32'(bus.accepted), 32'(exp_acc));
        check("cdb_valid", 32'(bus.cdb_valid), 32'(exp_valid));
        check("bcast_count", 32'(bus.bcast_count), 32'(exp_cnt));
        if (exp_acc != 4'b0000) begin
            push_expected(exp_acc, d);
            exp_cnt   = exp_cnt + 8'd1;
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Called at a falling edge while in reset: release and expect station 0.
    task automatic release_reset(input logic [15:0] d);
        rst_n = 1'b1;
        #1;
        check("accepted_after_release", 32'(bus.accepted), 32'h1);
        push_expected(4'b0001, d);
        exp_cnt   = 8'd1;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every broadcast beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.cdb_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(bus.cdb_tag), 32'(CDB_TAG_NONE));
            end else begin
                cdb_beat_t b;
                b = exp_q.pop_front();
                check("cdb_tag", 32'(bus.cdb_tag), 32'(b.tag));
                check("cdb_data", 32'(bus.cdb_data), 32'(b.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] rr_tab [7];
    logic [15:0] d;

    initial begin
        rr_tab = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_valid      = 1'b0;
        exp_cnt        = 8'd0;
        rst_n          = 1'b0;
        bus.req        = 4'b1111;
        bus.req_data   = 16'hDCBA;
        bus.cdb_enable = 1'b1;

        // Reset hold with all stations requesting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_accepted", 32'(bus.accepted), 32'h0);
        check("rst_cdb_valid", 32'(bus.cdb_valid), 32'h0);
        check("rst_bcast_count", 32'(bus.bcast_count), 32'h0);
        check("rst_cdb_tag", 32'(bus.cdb_tag), 32'h0);
        check("rst_cdb_data", 32'(bus.cdb_data), 32'h0);
        release_reset(16'hDCBA);

        // Round-robin: seven more grants, fresh data each cycle.
        for (int s = 1; s < 8; s++) begin
            d = {4'(s + 3), 4'(s + 2), 4'(s + 1), 4'(s)};
            step(4'b1111, d, 1'b1, rr_tab[s-1]);
        end
        step(4'b0000, 16'h0000, 1'b1, 4'b0000);
        check("rr_bcast_count_8", 32'(bus.bcast_count), 32'd8);

        // Pointer skip: grant station 1, then 0011 wraps to station 0.
        step(4'b0010, 16'h0050, 1'b1, 4'b0010);
        step(4'b0011, 16'h0097, 1'b1, 4'b0001);
        step(4'b0000, 16'h0000, 1'b1, 4'b0000);

        // Stall: enable low blocks the grant; tag holds the last beat.
        for (int s = 0; s < 3; s++) step(4'b0100, 16'h0E00, 1'b0, 4'b0000);
        check("stall_tag_hold", 32'(bus.cdb_tag), 32'h1);
        check("stall_data_hold", 32'(bus.cdb_data), 32'h7);
        step(4'b0100, 16'h0E00, 1'b1, 4'b0100);
        step(4'b0000, 16'h0000, 1'b1, 4'b0000);

        // Count wrap: 256 back-to-back grants starting at station 3.
        for (int k = 0; k < 256; k++) begin
            d = {4'(k + 12), 4'(k + 8), 4'(k + 4), 4'(k)};
            step(4'b1111, d, 1'b1, 4'b0001 << ((3 + k) % 4));
        end
        check("wrap_bcast_count", 32'(bus.bcast_count), 32'd11);

        // Mid-stream reset: beat in flight is dropped before the next edge.
        check("pre_reset_valid", 32'(bus.cdb_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", 32'(bus.cdb_valid), 32'h0);
        check("async_rst_accepted", 32'(bus.accepted), 32'h0);
        check("async_rst_tag", 32'(bus.cdb_tag), 32'h0);
        check("async_rst_count", 32'(bus.bcast_count), 32'h0);
        bus.req_data = 16'h4321;
        @(negedge clk);
        release_reset(16'h4321);
        step(4'b0000, 16'h0000, 1'b1, 4'b0000);
        step(4'b0000, 16'h0000, 1'b1, 4'b0000);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
